// File: rtl/axi_lsu_xbar_demux_if.sv
// axi_lsu_xbar_demux_if: LSU-side AXI4 port plus the per-slave ports of the LSU demux
interface axi_lsu_xbar_demux_if #(
  parameter int NUM_SLV = 2,
  parameter int TAG_W = 3,
  parameter int ATTR_W = 21
);
  logic lsu_axi_awvalid, lsu_axi_awready;
  logic [TAG_W-1:0] lsu_axi_awid;
  logic [31:0] lsu_axi_awaddr;
  logic [7:0] lsu_axi_awlen;
  logic [ATTR_W-1:0] lsu_axi_awattr;
  logic lsu_axi_wvalid, lsu_axi_wready, lsu_axi_wlast;
  logic [63:0] lsu_axi_wdata;
  logic [7:0] lsu_axi_wstrb;
  logic lsu_axi_bvalid, lsu_axi_bready;
  logic [TAG_W-1:0] lsu_axi_bid;
  logic [1:0] lsu_axi_bresp;
  logic lsu_axi_arvalid, lsu_axi_arready;
  logic [TAG_W-1:0] lsu_axi_arid;
  logic [31:0] lsu_axi_araddr;
  logic [7:0] lsu_axi_arlen;
  logic [ATTR_W-1:0] lsu_axi_arattr;
  logic lsu_axi_rvalid, lsu_axi_rready, lsu_axi_rlast;
  logic [TAG_W-1:0] lsu_axi_rid;
  logic [63:0] lsu_axi_rdata;
  logic [1:0] lsu_axi_rresp;
  logic [NUM_SLV-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NUM_SLV-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [TAG_W-1:0] m_awid, m_arid;
  logic [31:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [ATTR_W-1:0] m_awattr, m_arattr;
  logic [63:0] m_wdata;
  logic [7:0] m_wstrb;
  logic m_wlast;
  logic [NUM_SLV-1:0][TAG_W-1:0] m_bid, m_rid;
  logic [NUM_SLV-1:0][1:0] m_bresp, m_rresp;
  logic [NUM_SLV-1:0][63:0] m_rdata;
  modport slave (
    input lsu_axi_awvalid, lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awattr,
    input lsu_axi_wvalid, lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast, lsu_axi_bready,
    input lsu_axi_arvalid, lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arattr, lsu_axi_rready,
    input m_awready, m_wready, m_bvalid, m_bid, m_bresp, m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    output lsu_axi_awready, lsu_axi_wready, lsu_axi_bvalid, lsu_axi_bid, lsu_axi_bresp,
    output lsu_axi_arready, lsu_axi_rvalid, lsu_axi_rid, lsu_axi_rdata, lsu_axi_rresp, lsu_axi_rlast,
    output m_awvalid, m_awid, m_awaddr, m_awlen, m_awattr, m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arattr, m_rready
  );
  modport master (
    output lsu_axi_awvalid, lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awattr,
    output lsu_axi_wvalid, lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast, lsu_axi_bready,
    output lsu_axi_arvalid, lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arattr, lsu_axi_rready,
    output m_awready, m_wready, m_bvalid, m_bid, m_bresp, m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    input lsu_axi_awready, lsu_axi_wready, lsu_axi_bvalid, lsu_axi_bid, lsu_axi_bresp,
    input lsu_axi_arready, lsu_axi_rvalid, lsu_axi_rid, lsu_axi_rdata, lsu_axi_rresp, lsu_axi_rlast,
    input m_awvalid, m_awid, m_awaddr, m_awlen, m_awattr, m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    input m_arvalid, m_arid, m_araddr, m_arlen, m_arattr, m_rready
  );
endinterface

// File: rtl/axi_lsu_xbar_demux.sv
// axi_lsu_xbar_demux: 1-to-NUM_SLV AXI4 demux for the LSU port with in-order tracking and a DECERR responder
module axi_lsu_xbar_demux #(
  parameter int NUM_SLV = 2,
  parameter int TAG_W = 3,
  parameter int MAX_OUTST = 4,
  parameter int ATTR_W = 21,
  parameter logic [NUM_SLV-1:0][31:0] SLV_LO = {32'h8000_0000, 32'h2000_0000},
  parameter logic [NUM_SLV-1:0][31:0] SLV_HI = {32'hFFFF_FFFF, 32'h7FFF_FFFF}
) (
  input logic clk,
  input logic rst,
  axi_lsu_xbar_demux_if.slave bus
);
  localparam int SW = $clog2(NUM_SLV + 1);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [SW-1:0] ERR = SW'(NUM_SLV);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTST);
  logic [SW-1:0] ar_tgt, aw_tgt, rd_sel, wr_sel;
  logic [CW-1:0] rd_cnt, wr_cnt, w_pend;
  logic [TAG_W-1:0] er_id, ew_id;
  logic [7:0] er_left;
  logic er_busy, ew_b, rd_ok, wr_ok, ar_hs, aw_hs, r_hs, w_hs, b_hs;
  function automatic logic [SW-1:0] dec(input logic [31:0] a);
    dec = ERR;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if (a >= SLV_LO[i] && a <= SLV_HI[i]) dec = SW'(i);
  endfunction
  assign bus.m_awid = bus.lsu_axi_awid;
  assign bus.m_awaddr = bus.lsu_axi_awaddr;
  assign bus.m_awlen = bus.lsu_axi_awlen;
  assign bus.m_awattr = ATTR_W'(bus.lsu_axi_awattr);
  assign bus.m_arid = bus.lsu_axi_arid;
  assign bus.m_araddr = bus.lsu_axi_araddr;
  assign bus.m_arlen = bus.lsu_axi_arlen;
  assign bus.m_arattr = ATTR_W'(bus.lsu_axi_arattr);
  assign bus.m_wdata = bus.lsu_axi_wdata;
  assign bus.m_wstrb = bus.lsu_axi_wstrb;
  assign bus.m_wlast = bus.lsu_axi_wlast;
  assign ar_hs = bus.lsu_axi_arvalid && bus.lsu_axi_arready;
  assign aw_hs = bus.lsu_axi_awvalid && bus.lsu_axi_awready;
  assign r_hs = bus.lsu_axi_rvalid && bus.lsu_axi_rready;
  assign w_hs = bus.lsu_axi_wvalid && bus.lsu_axi_wready;
  assign b_hs = bus.lsu_axi_bvalid && bus.lsu_axi_bready;
  // ERR-selected defaults first; a matching real slave overrides them in the loop
  always_comb begin
    ar_tgt = dec(bus.lsu_axi_araddr);
    aw_tgt = dec(bus.lsu_axi_awaddr);
    rd_ok = !rst && rd_cnt < MAXC && (rd_cnt == '0 || ar_tgt == rd_sel);
    wr_ok = !rst && wr_cnt < MAXC && (wr_cnt == '0 || aw_tgt == wr_sel);
    bus.m_arvalid = '0;
    bus.m_awvalid = '0;
    bus.m_wvalid = '0;
    bus.m_rready = '0;
    bus.m_bready = '0;
    bus.lsu_axi_arready = rd_ok && ar_tgt == ERR && rd_cnt == '0;
    bus.lsu_axi_awready = wr_ok && aw_tgt == ERR && wr_cnt == '0;
    bus.lsu_axi_wready = w_pend != '0 && wr_sel == ERR;
    bus.lsu_axi_rvalid = rd_sel == ERR && er_busy;
    bus.lsu_axi_rid = er_id;
    bus.lsu_axi_rdata = '0;
    bus.lsu_axi_rresp = 2'b11;
    bus.lsu_axi_rlast = er_left == '0;
    bus.lsu_axi_bvalid = wr_sel == ERR && ew_b;
    bus.lsu_axi_bid = ew_id;
    bus.lsu_axi_bresp = 2'b11;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (ar_tgt == SW'(i)) begin
        bus.m_arvalid[i] = rd_ok && bus.lsu_axi_arvalid;
        bus.lsu_axi_arready = rd_ok && bus.m_arready[i];
      end
      if (aw_tgt == SW'(i)) begin
        bus.m_awvalid[i] = wr_ok && bus.lsu_axi_awvalid;
        bus.lsu_axi_awready = wr_ok && bus.m_awready[i];
      end
      if (rd_sel == SW'(i)) begin
        bus.m_rready[i] = rd_cnt != '0 && bus.lsu_axi_rready;
        bus.lsu_axi_rvalid = rd_cnt != '0 && bus.m_rvalid[i];
        bus.lsu_axi_rid = bus.m_rid[i];
        bus.lsu_axi_rdata = bus.m_rdata[i];
        bus.lsu_axi_rresp = bus.m_rresp[i];
        bus.lsu_axi_rlast = bus.m_rlast[i];
      end
      if (wr_sel == SW'(i)) begin
        bus.m_wvalid[i] = w_pend != '0 && bus.lsu_axi_wvalid;
        bus.lsu_axi_wready = w_pend != '0 && bus.m_wready[i];
        bus.m_bready[i] = wr_cnt != '0 && bus.lsu_axi_bready;
        bus.lsu_axi_bvalid = wr_cnt != '0 && bus.m_bvalid[i];
        bus.lsu_axi_bid = bus.m_bid[i];
        bus.lsu_axi_bresp = bus.m_bresp[i];
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_sel <= '0;
      wr_sel <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      w_pend <= '0;
      er_busy <= 1'b0;
      er_id <= '0;
      er_left <= '0;
      ew_b <= 1'b0;
      ew_id <= '0;
    end else begin
      if (ar_hs) rd_sel <= ar_tgt;
      if (aw_hs) wr_sel <= aw_tgt;
      rd_cnt <= rd_cnt + CW'(ar_hs) - CW'(r_hs && bus.lsu_axi_rlast);
      wr_cnt <= wr_cnt + CW'(aw_hs) - CW'(b_hs);
      w_pend <= w_pend + CW'(aw_hs) - CW'(w_hs && bus.lsu_axi_wlast);
      if (ar_hs && ar_tgt == ERR) begin
        er_busy <= 1'b1;
        er_id <= bus.lsu_axi_arid;
        er_left <= bus.lsu_axi_arlen;
      end else if (r_hs && rd_sel == ERR) begin
        er_busy <= er_left != '0;
        er_left <= er_left - 8'd1;
      end
      if (aw_hs && aw_tgt == ERR) ew_id <= bus.lsu_axi_awid;
      if (w_hs && bus.lsu_axi_wlast && wr_sel == ERR) ew_b <= 1'b1;
      else if (b_hs && wr_sel == ERR) ew_b <= 1'b0;
    end
endmodule

// File: tb/tb_axi_lsu_xbar_demux.sv
// tb_axi_lsu_xbar_demux: directed + randomized checks of the LSU demux against a transaction-queue model
module tb_axi_lsu_xbar_demux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int wpend = 0;
  always #5 clk = ~clk;
  axi_lsu_xbar_demux_if #(.NUM_SLV(2), .TAG_W(3), .ATTR_W(21)) bus ();
  axi_lsu_xbar_demux #(.NUM_SLV(2), .TAG_W(3), .MAX_OUTST(4), .ATTR_W(21)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct { int t; logic [2:0] id; logic [7:0] len; } txn_t;
  txn_t rq[$];
  txn_t wq[$];
  logic [31:0] edges [5] = '{32'h1FFF_FFFF, 32'h2000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int tgt_of(input logic [31:0] a);
    if (a >= 32'h2000_0000 && a <= 32'h7FFF_FFFF) return 0;
    if (a >= 32'h8000_0000) return 1;
    return 2;
  endfunction
  function automatic bit ok_model(input int t, input int n, input int head);
    if (n >= 4) return 0;
    if (t == 2) return n == 0;
    return n == 0 || head == t;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {bus.lsu_axi_awvalid, bus.lsu_axi_wvalid, bus.lsu_axi_bready, bus.lsu_axi_arvalid, bus.lsu_axi_rready} = '0;
    {bus.lsu_axi_awid, bus.lsu_axi_awaddr, bus.lsu_axi_awlen, bus.lsu_axi_awattr} = '0;
    {bus.lsu_axi_arid, bus.lsu_axi_araddr, bus.lsu_axi_arlen, bus.lsu_axi_arattr} = '0;
    {bus.lsu_axi_wdata, bus.lsu_axi_wstrb, bus.lsu_axi_wlast} = '0;
    {bus.m_awready, bus.m_wready, bus.m_bvalid, bus.m_arready, bus.m_rvalid, bus.m_rlast} = '0;
    bus.m_bid = '0;
    bus.m_bresp = '0;
    bus.m_rid = '0;
    bus.m_rresp = '0;
    bus.m_rdata = '0;
  endtask
  task automatic issue_ar(input logic [31:0] a, input logic [2:0] id, input logic [7:0] len);
    int t;
    bit ok;
    logic [20:0] at;
    t = tgt_of(a);
    ok = ok_model(t, rq.size(), rq.size() != 0 ? rq[0].t : -1);
    at = 21'($urandom);
    bus.lsu_axi_arvalid = 1'b1;
    bus.lsu_axi_araddr = a;
    bus.lsu_axi_arid = id;
    bus.lsu_axi_arlen = len;
    bus.lsu_axi_arattr = at;
    bus.m_arready = 2'b11;
    #1;
    chk("m_arvalid", bus.m_arvalid, (ok && t < 2) ? (64'd1 << t) : 64'd0);
    chk("arready", bus.lsu_axi_arready, ok);
    chk("m_araddr", bus.m_araddr, a);
    chk("m_arid_len_attr", {bus.m_arid, bus.m_arlen, bus.m_arattr}, {id, len, at});
    tick();
    bus.lsu_axi_arvalid = 1'b0;
    if (ok) rq.push_back('{t: t, id: id, len: len});
    chk("rd_cnt", dut.rd_cnt, rq.size());
  endtask
  task automatic drain_read();
    txn_t x;
    int b, cyc;
    logic [63:0] d;
    logic [1:0] rs;
    bit rr;
    x = rq[0];
    b = 0;
    cyc = 0;
    while (b <= int'(x.len) && cyc < 64) begin
      d = {$urandom, $urandom};
      rs = 2'($urandom);
      rr = $urandom_range(0, 3) != 0;
      bus.m_rvalid = 2'b11;
      for (int i = 0; i < 2; i++) begin
        bus.m_rid[i] = (i == x.t) ? x.id : ~x.id;
        bus.m_rdata[i] = (i == x.t) ? d : ~d;
        bus.m_rresp[i] = (i == x.t) ? rs : ~rs;
        bus.m_rlast[i] = (i == x.t) ? (b == int'(x.len)) : 1'b1;
      end
      bus.lsu_axi_rready = rr;
      #1;
      chk("rvalid", bus.lsu_axi_rvalid, 1'b1);
      chk("rid", bus.lsu_axi_rid, x.id);
      chk("rdata", bus.lsu_axi_rdata, x.t == 2 ? 64'd0 : d);
      chk("rresp", bus.lsu_axi_rresp, x.t == 2 ? 2'b11 : rs);
      chk("rlast", bus.lsu_axi_rlast, b == int'(x.len));
      chk("m_rready", bus.m_rready, (x.t < 2 && rr) ? (64'd1 << x.t) : 64'd0);
      tick();
      if (rr) b++;
      cyc++;
    end
    bus.m_rvalid = 2'b00;
    bus.lsu_axi_rready = 1'b0;
    void'(rq.pop_front());
    chk("rd_cnt_after_r", dut.rd_cnt, rq.size());
  endtask
  task automatic issue_aw(input logic [31:0] a, input logic [2:0] id, input logic [7:0] len);
    int t;
    bit ok;
    t = tgt_of(a);
    ok = ok_model(t, wq.size(), wq.size() != 0 ? wq[0].t : -1);
    bus.lsu_axi_awvalid = 1'b1;
    bus.lsu_axi_awaddr = a;
    bus.lsu_axi_awid = id;
    bus.lsu_axi_awlen = len;
    bus.lsu_axi_awattr = 21'($urandom);
    bus.m_awready = 2'b11;
    #1;
    chk("m_awvalid", bus.m_awvalid, (ok && t < 2) ? (64'd1 << t) : 64'd0);
    chk("awready", bus.lsu_axi_awready, ok);
    chk("m_awaddr", bus.m_awaddr, a);
    chk("m_awattr", bus.m_awattr, bus.lsu_axi_awattr);
    tick();
    bus.lsu_axi_awvalid = 1'b0;
    if (ok) begin
      wq.push_back('{t: t, id: id, len: len});
      wpend++;
    end
    chk("wr_cnt", dut.wr_cnt, wq.size());
    chk("w_pend", dut.w_pend, wpend);
  endtask
  task automatic send_w();
    txn_t x;
    int b, cyc;
    logic [63:0] d;
    logic [7:0] s;
    bit wr, er;
    x = wq[wq.size() - 1];
    b = 0;
    cyc = 0;
    while (b <= int'(x.len) && cyc < 64) begin
      d = {$urandom, $urandom};
      s = 8'($urandom);
      wr = $urandom_range(0, 3) != 0;
      bus.lsu_axi_wvalid = 1'b1;
      bus.lsu_axi_wdata = d;
      bus.lsu_axi_wstrb = s;
      bus.lsu_axi_wlast = b == int'(x.len);
      for (int i = 0; i < 2; i++) bus.m_wready[i] = (i == x.t) ? wr : !wr;
      er = x.t == 2 ? 1'b1 : wr;
      #1;
      chk("wready", bus.lsu_axi_wready, er);
      chk("m_wvalid", bus.m_wvalid, x.t < 2 ? (64'd1 << x.t) : 64'd0);
      chk("m_wpayload", {bus.m_wdata, bus.m_wstrb, bus.m_wlast}, {d, s, b == int'(x.len)});
      tick();
      if (er) b++;
      cyc++;
    end
    bus.lsu_axi_wvalid = 1'b0;
    bus.lsu_axi_wlast = 1'b0;
    bus.m_wready = 2'b00;
    wpend--;
    chk("w_pend_after_w", dut.w_pend, wpend);
  endtask
  task automatic drain_b();
    txn_t x;
    int cyc;
    bit br, done;
    logic [1:0] rs;
    x = wq[0];
    cyc = 0;
    done = 0;
    while (!done && cyc < 32) begin
      rs = 2'($urandom);
      br = $urandom_range(0, 1) != 0;
      bus.m_bvalid = 2'b11;
      for (int i = 0; i < 2; i++) begin
        bus.m_bid[i] = (i == x.t) ? x.id : ~x.id;
        bus.m_bresp[i] = (i == x.t) ? rs : ~rs;
      end
      bus.lsu_axi_bready = br;
      #1;
      chk("bvalid", bus.lsu_axi_bvalid, 1'b1);
      chk("bid", bus.lsu_axi_bid, x.id);
      chk("bresp", bus.lsu_axi_bresp, x.t == 2 ? 2'b11 : rs);
      chk("m_bready", bus.m_bready, (x.t < 2 && br) ? (64'd1 << x.t) : 64'd0);
      tick();
      done = br;
      cyc++;
    end
    bus.m_bvalid = 2'b00;
    bus.lsu_axi_bready = 1'b0;
    void'(wq.pop_front());
    chk("wr_cnt_after_b", dut.wr_cnt, wq.size());
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_lsu_valid_ready"}, {bus.lsu_axi_awready, bus.lsu_axi_wready, bus.lsu_axi_bvalid,
        bus.lsu_axi_arready, bus.lsu_axi_rvalid}, 5'b0);
    chk({tag, "_m_valid_ready"}, {bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready}, 10'b0);
    chk({tag, "_counts"}, {dut.rd_cnt, dut.wr_cnt, dut.w_pend}, 9'b0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a;
    idle();
    bus.lsu_axi_rready = 1'b1;
    bus.lsu_axi_bready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    idle();
    rst = 1'b0;
    tick();
    issue_ar(32'h2000_0010, 3'd2, 8'd3);
    drain_read();
    issue_aw(32'h8000_0000, 3'd6, 8'd1);
    send_w();
    drain_b();
    for (int k = 0; k < 4; k++) issue_ar(32'h8000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF)), 3'(k), 8'd0);
    issue_ar(32'h9000_0040, 3'd7, 8'd1);
    drain_read();
    issue_ar(32'h9000_0040, 3'd7, 8'd1);
    while (rq.size() != 0) drain_read();
    issue_ar(32'h3000_0000, 3'd1, 8'd1);
    issue_ar(32'hA000_0000, 3'd3, 8'd0);
    drain_read();
    issue_ar(32'hA000_0000, 3'd3, 8'd0);
    drain_read();
    issue_ar(32'h1000_0000, 3'd5, 8'd2);
    issue_ar(32'h1000_0000, 3'd4, 8'd0);
    drain_read();
    issue_aw(32'h0000_0000, 3'd3, 8'd2);
    send_w();
    drain_b();
    bus.lsu_axi_wvalid = 1'b1;
    bus.m_wready = 2'b11;
    #1;
    chk("w_before_aw_wready", bus.lsu_axi_wready, 1'b0);
    chk("w_before_aw_m_wvalid", bus.m_wvalid, 2'b00);
    tick();
    chk("w_before_aw_wready2", bus.lsu_axi_wready, 1'b0);
    issue_aw(32'h2000_0200, 3'd1, 8'd0);
    send_w();
    drain_b();
    foreach (edges[k]) begin
      issue_ar(edges[k], 3'($urandom), 8'($urandom_range(0, 2)));
      drain_read();
      issue_aw(edges[k], 3'($urandom), 8'($urandom_range(0, 2)));
      send_w();
      drain_b();
    end
    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      issue_ar(a, 3'($urandom), 8'($urandom_range(0, 3)));
      if (n % 2 == 1) issue_ar(a, 3'($urandom), 8'($urandom_range(0, 3)));
      while (rq.size() != 0) drain_read();
      a = $urandom;
      issue_aw(a, 3'($urandom), 8'($urandom_range(0, 3)));
      send_w();
      drain_b();
    end
    issue_ar(32'h2000_0100, 3'd1, 8'd3);
    bus.m_rvalid = 2'b01;
    bus.m_rlast = 2'b00;
    bus.lsu_axi_rready = 1'b1;
    tick();
    issue_aw(32'h2000_0300, 3'd2, 8'd3);
    bus.lsu_axi_wvalid = 1'b1;
    bus.m_wready = 2'b11;
    bus.lsu_axi_arvalid = 1'b1;
    bus.lsu_axi_araddr = 32'h2000_0000;
    bus.m_arready = 2'b11;
    bus.lsu_axi_awvalid = 1'b1;
    bus.lsu_axi_awaddr = 32'h2000_0000;
    bus.m_awready = 2'b11;
    bus.m_bvalid = 2'b11;
    bus.lsu_axi_bready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_quiet("mid_reset");
    rq.delete();
    wq.delete();
    wpend = 0;
    idle();
    tick();
    rst = 1'b0;
    tick();
    issue_ar(32'h8000_1000, 3'd6, 8'd1);
    drain_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lsu_xbar_demux.md
Name: axi_lsu_xbar_demux

Overview:
Parametrised 1-to-NUM_SLV AXI4 demultiplexer between the EL2 LSU master port and downstream slaves (memory, AXI bridge, peripherals). It decodes AR/AW addresses against per-slave inclusive ranges and tracks outstanding transactions so responses return in order. W beats are steered to the slave that accepted the matching AW. Unmapped addresses are answered by an internal DECERR responder.

Parameters:
NUM_SLV, 2, number of downstream slave ports
TAG_W, pt.LSU_BUS_TAG, AXI ID width
MAX_OUTST, 4, max outstanding transactions per direction (reads, writes)
SLV_LO, {32'h2000_0000, 32'h8000_0000}, per-slave inclusive range base (index 0 first)
SLV_HI, {32'h7FFF_FFFF, 32'hFFFF_FFFF}, per-slave inclusive range top
ATTR_W, 21, packed sideband {region,lock,cache,prot,qos,burst,size}, forwarded untouched

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
lsu_axi_awvalid/awid/awaddr/awlen/awattr  in  1/TAG_W/32/8/ATTR_W  upstream AW
lsu_axi_awready  out  1  upstream AW ready
lsu_axi_wvalid/wdata/wstrb/wlast  in  1/64/8/1  upstream W
lsu_axi_wready  out  1  upstream W ready
lsu_axi_bvalid/bid/bresp  out  1/TAG_W/2  upstream B
lsu_axi_bready  in  1  upstream B ready
lsu_axi_arvalid/arid/araddr/arlen/arattr  in  1/TAG_W/32/8/ATTR_W  upstream AR
lsu_axi_arready  out  1  upstream AR ready
lsu_axi_rvalid/rid/rdata/rresp/rlast  out  1/TAG_W/64/2/1  upstream R
lsu_axi_rready  in  1  upstream R ready
m_awvalid/m_wvalid/m_bready/m_arvalid/m_rready  out  [NUM_SLV] each  per-slave handshake outputs
m_awready/m_wready/m_bvalid/m_arready/m_rvalid  in  [NUM_SLV] each  per-slave handshake inputs
m_awid/awaddr/awlen/awattr, m_wdata/wstrb/wlast, m_arid/araddr/arlen/arattr  out  shared widths  payloads broadcast to all slaves
m_bid/bresp, m_rid/rdata/rresp/rlast  in  [NUM_SLV][TAG_W/2], [NUM_SLV][TAG_W/64/2/1]  per-slave responses

Behaviour:
- Decode: target = lowest index i with SLV_LO[i] <= addr <= SLV_HI[i]; no match -> target = ERR (internal). Combinational, zero latency.
- Reset (async): rd_cnt, wr_cnt, w_pend = 0; rd_sel, wr_sel = 0; ERR responders idle; all valid/ready outputs 0 (valid/ready gating follows state, so outputs are 0 immediately).
- Read accept: AR forwarded (m_arvalid[target] = arvalid, lsu_axi_arready = m_arready[target]) only if rd_cnt < MAX_OUTST and (rd_cnt == 0 or target == rd_sel). Otherwise arready = 0 and all m_arvalid = 0.
- On AR handshake: rd_sel <= target; rd_cnt++.
- R path: muxed from rd_sel; m_rready[rd_sel] = lsu_axi_rready. rd_cnt-- on rvalid & rready & rlast. Same-cycle inc and dec -> net unchanged.
- Write accept: same rule using wr_cnt/wr_sel. On AW handshake: wr_cnt++, w_pend++.
- W path: routed to wr_sel only while w_pend > 0; else wready = 0. w_pend-- on W handshake with wlast. W never precedes its AW through this block.
- B path: muxed from wr_sel; wr_cnt-- on B handshake.
- Target switch: stalls until the direction's count drains to 0. Reads and writes are independent.
- ERR read: accepts AR only when rd_cnt == 0. Captures arid and arlen, then drives arlen+1 R beats: rresp = 2'b11, rdata = 0, rlast on the final beat, and honours rready backpressure.
- ERR write: accepts AW only when wr_cnt == 0. Sinks W (wready = 1) through wlast, then bvalid with bresp = 2'b11 and the captured bid.
- Counters saturate by design: acceptance is blocked at MAX_OUTST, so a count never exceeds it. Count width is $clog2(MAX_OUTST+1).
- Reset mid-burst discards all tracking. Slaves must be reset on the same rst.

Test Plan:
- AR 0x2000_0010 arlen 3 -> m_arvalid[0] only; 4 R beats from slave 0 returned with matching rid; rd_cnt goes 0->1->0.
- AW 0x8000_0000 plus 2 W beats, then B -> m_awvalid[1] and m_wvalid[1] only; bresp passed through; wr_cnt returns to 0.
- 4 ARs to slave 1 with no R, then a 5th AR -> arready = 0 on the 5th until the first rlast is accepted.
- AR to slave 1 while 1 read to slave 0 is outstanding -> stall until slave 0 rlast, then forwarded to slave 1.
- AR 0x1000_0000 arlen 2 id 5 -> 3 beats rresp = 11, rdata = 0, rid = 5, rlast on beat 3; AW 0x0 -> W sunk, bresp = 11.
- wvalid asserted before awvalid -> wready = 0 until AW handshake; rst asserted mid-burst -> all outputs 0 and counts 0 immediately.
